pipeline_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It drives the enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers. It does so from three hazard sources: load-use dependencies, branch mispredicts resolved in EX, and a data-memory request/acknowledge handshake. It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/sat_counter.sv | 24 ++
 rtl/pipeline_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    // Winning hazard for the current cycle; drives the output decode.
    typedef enum logic [1:0] {
        HZ_NONE     = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_MISPRED  = 2'd2,
        HZ_MEM      = 2'd3
    } hazard_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs, register enables/flushes and status of the pipeline controller.
// master: pipeline side (drives hazards, receives controls); slave: controller.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [pipe_ctrl_pkg::REG_AW-1:0] id_rs1_addr;
    logic [pipe_ctrl_pkg::REG_AW-1:0] id_rs2_addr;
    logic                             id_rs1_used;
    logic                             id_rs2_used;
    logic [pipe_ctrl_pkg::REG_AW-1:0] ex_rd_addr;
    logic                             ex_is_load;
    logic                             ex_mispredict;
    logic                             mem_req;
    logic                             mem_ack;

    logic                             pc_en;
    logic                             IF_ID_en;
    logic                             ID_EX_en;
    logic                             EX_MEM_en;
    logic                             if_id_flush;
    logic                             id_ex_flush;
    logic [CNT_W-1:0]                 stall_cnt;
    logic [CNT_W-1:0]                 flush_cnt;
    logic                             mem_timeout;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_rd_addr, ex_is_load, ex_mispredict, mem_req, mem_ack,
        input  pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, if_id_flush, id_ex_flush,
               stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_rd_addr, ex_is_load, ex_mispredict, mem_req, mem_ack,
        output pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, if_id_flush, id_ex_flush,
               stall_cnt, flush_cnt, mem_timeout
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), inc (count enable), clr (sync clear),
// count (registered value).
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the
// load-use/mispredict/memory hazard inputs, the PC/IF_ID/ID_EX/EX_MEM enables,
// the IF/ID and ID/EX flushes, saturating stall/flush counters and the sticky
// memory-timeout flag.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    pipeline_ctrl_if.slave  bus
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e      state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout_q, timeout_d;

    hazard_e hz_c;
    logic    load_use_c;
    logic    mem_stall_c;
    logic    pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c;
    logic    if_id_flush_c, id_ex_flush_c;

    // Hazard detection and prioritisation.
    always_comb begin
        load_use_c = bus.ex_is_load && (bus.ex_rd_addr != REG_X0) &&
                     ((bus.id_rs1_used && (bus.id_rs1_addr == bus.ex_rd_addr)) ||
                      (bus.id_rs2_used && (bus.id_rs2_addr == bus.ex_rd_addr)));
        // The ack cycle itself is not stalled, so an ack in MEM_WAIT releases at once.
        mem_stall_c = !bus.mem_ack && (bus.mem_req || (state_q == MEM_WAIT));
        hz_c = HZ_NONE;
        if (mem_stall_c) begin
            hz_c = HZ_MEM;
        end else if (bus.ex_mispredict) begin
            hz_c = HZ_MISPRED;
        end else if (load_use_c) begin
            hz_c = HZ_LOAD_USE;
        end
    end

    // Next state, timeout tracking and control decode.
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        timeout_d     = timeout_q;
        pc_en_c       = 1'b0;
        if_id_en_c    = 1'b0;
        id_ex_en_c    = 1'b0;
        ex_mem_en_c   = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;

        case (state_q)
            RUN: begin
                tmo_d = '0;
                if (bus.mem_req && !bus.mem_ack) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // Count this waiting cycle; the access itself is never aborted.
                if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    state_d = RUN;
                    tmo_d   = '0;
                end else if (tmo_q != TMO_W'(MEM_TIMEOUT)) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = RUN;
        endcase

        if (rst_n) begin
            case (hz_c)
                HZ_NONE: begin
                    pc_en_c     = 1'b1;
                    if_id_en_c  = 1'b1;
                    id_ex_en_c  = 1'b1;
                    ex_mem_en_c = 1'b1;
                end
                HZ_LOAD_USE: begin
                    id_ex_en_c    = 1'b1;
                    ex_mem_en_c   = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
                HZ_MISPRED: begin
                    pc_en_c       = 1'b1;
                    if_id_en_c    = 1'b1;
                    id_ex_en_c    = 1'b1;
                    ex_mem_en_c   = 1'b1;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.pc_en       = pc_en_c;
    assign bus.IF_ID_en    = if_id_en_c;
    assign bus.ID_EX_en    = id_ex_en_c;
    assign bus.EX_MEM_en   = ex_mem_en_c;
    assign bus.if_id_flush = if_id_flush_c;
    assign bus.id_ex_flush = id_ex_flush_c;
    assign bus.mem_timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_en_c),
        .clr   (1'b0),
        .count (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hz_c == HZ_MISPRED),
        .clr   (1'b0),
        .count (bus.flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (CNT_W = 3, MEM_TIMEOUT = 4).
module tb_pipeline_ctrl;

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned TMO     = 4;
    localparam int          CNT_MAX = 7;

    logic clk;
    logic rst_n;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory-busy flag, cycles spent waiting, event tallies.
    bit m_waiting;
    int m_wait_cycles;
    bit m_tmo;
    int m_stalls;
    int m_flushes;

    // 0 normal, 1 load-use, 2 mispredict, 3 memory wait
    function automatic int classify();
        bit lu;
        if (!bus.mem_ack && (bus.mem_req || m_waiting)) return 3;
        if (bus.ex_mispredict) return 2;
        lu = bus.ex_is_load && (bus.ex_rd_addr != 0) &&
             ((bus.id_rs1_used && bus.id_rs1_addr == bus.ex_rd_addr) ||
              (bus.id_rs2_used && bus.id_rs2_addr == bus.ex_rd_addr));
        if (lu) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_waiting = 0; m_wait_cycles = 0; m_tmo = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            int c;
            c = classify();
            if ((c == 1 || c == 3) && m_stalls < CNT_MAX) m_stalls++;
            if (c == 2 && m_flushes < CNT_MAX) m_flushes++;
            if (m_waiting) begin
                m_wait_cycles++;
                if (m_wait_cycles == TMO) m_tmo = 1;
                if (bus.mem_ack) begin
                    m_waiting = 0;
                    m_wait_cycles = 0;
                end
            end else if (bus.mem_req && !bus.mem_ack) begin
                m_waiting = 1;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        int  c;
        bit  live;
        live = rst_n;
        c = classify();
        check("pc_en",       bus.pc_en,       live && (c == 0 || c == 2));
        check("IF_ID_en",    bus.IF_ID_en,    live && (c == 0 || c == 2));
        check("ID_EX_en",    bus.ID_EX_en,    live && (c != 3));
        check("EX_MEM_en",   bus.EX_MEM_en,   live && (c != 3));
        check("if_id_flush", bus.if_id_flush, live && (c == 2));
        check("id_ex_flush", bus.id_ex_flush, live && (c == 1 || c == 2));
        check("stall_cnt",   int'(bus.stall_cnt), m_stalls);
        check("flush_cnt",   int'(bus.flush_cnt), m_flushes);
        check("mem_timeout", bus.mem_timeout, m_tmo);
    end

    task automatic clear_in();
        bus.id_rs1_addr = '0; bus.id_rs2_addr = '0;
        bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
        bus.ex_rd_addr = '0; bus.ex_is_load = 1'b0; bus.ex_mispredict = 1'b0;
        bus.mem_req = 1'b0; bus.mem_ack = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        bus.ex_is_load = 1'b1; bus.ex_rd_addr = 5'd5;
        bus.id_rs2_addr = 5'd5; bus.id_rs2_used = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        repeat (2) @(negedge clk);
        check("rst pc_en", bus.pc_en, 0);
        check("rst id_ex_flush", bus.id_ex_flush, 0);
        check("rst stall_cnt", int'(bus.stall_cnt), 0);
        cyc(); rst_n = 1'b1;
        @(negedge clk); check("idle pc_en", bus.pc_en, 1);

        // load-use
        cyc(); set_load_use();
        @(negedge clk);
        check("lu pc_en", bus.pc_en, 0);
        check("lu IF_ID_en", bus.IF_ID_en, 0);
        check("lu id_ex_flush", bus.id_ex_flush, 1);
        cyc(); clear_in();
        @(negedge clk); check("lu stall_cnt", int'(bus.stall_cnt), 1);

        // load to x0: no hazard
        cyc(); bus.ex_is_load = 1'b1; bus.ex_rd_addr = 5'd0;
        bus.id_rs1_addr = 5'd0; bus.id_rs1_used = 1'b1;
        @(negedge clk); check("x0 pc_en", bus.pc_en, 1);

        // mispredict
        cyc(); clear_in(); bus.ex_mispredict = 1'b1;
        @(negedge clk);
        check("mp if_id_flush", bus.if_id_flush, 1);
        check("mp pc_en", bus.pc_en, 1);
        cyc(); clear_in();
        @(negedge clk); check("mp flush_cnt", int'(bus.flush_cnt), 1);

        // mispredict + load-use together
        cyc(); set_load_use(); bus.ex_mispredict = 1'b1;
        @(negedge clk);
        check("mplu pc_en", bus.pc_en, 1);
        check("mplu if_id_flush", bus.if_id_flush, 1);
        cyc(); clear_in();
        @(negedge clk);
        check("mplu stall_cnt", int'(bus.stall_cnt), 1);
        check("mplu flush_cnt", int'(bus.flush_cnt), 2);

        // memory wait 3 cycles with a mispredict held
        cyc(); bus.mem_req = 1'b1; bus.ex_mispredict = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mw pc_en", bus.pc_en, 0);
            check("mw if_id_flush", bus.if_id_flush, 0);
            cyc();
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        check("ack pc_en", bus.pc_en, 1);
        check("ack if_id_flush", bus.if_id_flush, 1);
        cyc(); clear_in();
        @(negedge clk);
        check("mw stall_cnt", int'(bus.stall_cnt), 4);
        check("mw flush_cnt", int'(bus.flush_cnt), 3);

        // req and ack together: no stall, stays in RUN
        cyc(); bus.mem_req = 1'b1; bus.mem_ack = 1'b1;
        @(negedge clk); check("reqack pc_en", bus.pc_en, 1);
        cyc(); clear_in();
        @(negedge clk); check("reqack next pc_en", bus.pc_en, 1);

        // timeout: 6 cycles without ack (1 in RUN, then 5 in MEM_WAIT)
        cyc(); bus.mem_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 5) check("tmo before", bus.mem_timeout, 0);
            if (i == 6) check("tmo set", bus.mem_timeout, 1);
            cyc();
        end
        bus.mem_ack = 1'b1;
        cyc(); clear_in();
        @(negedge clk);
        check("tmo sticky", bus.mem_timeout, 1);
        check("sat stall_cnt mw", int'(bus.stall_cnt), 7);

        // reset asserted mid-wait
        cyc(); bus.mem_req = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b0;
        @(negedge clk);
        check("rstw pc_en", bus.pc_en, 0);
        check("rstw mem_timeout", bus.mem_timeout, 0);
        check("rstw stall_cnt", int'(bus.stall_cnt), 0);
        check("rstw flush_cnt", int'(bus.flush_cnt), 0);
        cyc(); clear_in(); rst_n = 1'b1;
        @(negedge clk); check("rstw run pc_en", bus.pc_en, 1);

        // saturation: 10 load-use stalls
        cyc(); set_load_use();
        repeat (10) cyc();
        clear_in();
        @(negedge clk); check("sat stall_cnt", int'(bus.stall_cnt), 7);

        cyc();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
